// File: rtl/lmmi_initiator.sv
`default_nettype none
// ============================================================================
// Module      : lmmi_initiator
// Description : Turns one valid/ready command into one LMMI read or write
//               transaction and returns the result as a valid/ready response.
//               A bounded wait on each LMMI event ends in an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module lmmi_initiator #(
    parameter int OFFSET_W = 4,
    parameter int DATA_W   = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic                sync_clk_i,
    input  logic                sync_rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [OFFSET_W-1:0] cmd_offset_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                lmmi_request_o,
    output logic                lmmi_wr_rdn_o,
    output logic [OFFSET_W-1:0] lmmi_offset_o,
    output logic [DATA_W-1:0]   lmmi_wdata_o,
    input  logic                lmmi_ready_i,
    input  logic [DATA_W-1:0]   lmmi_rdata_i,
    input  logic                lmmi_rdata_valid_i,
    output logic                busy_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic             C_TO_EN    = (TIMEOUT > 0);

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_REQ    = 2'd1;
    localparam logic [1:0] C_RDWAIT = 2'd2;
    localparam logic [1:0] C_RESP   = 2'd3;

    logic [1:0]          state_q,  state_d;
    logic                wr_q,     wr_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;
    logic                err_q,    err_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                timeout_hit;

    always_ff @(posedge sync_clk_i) begin
        if (sync_rst_i) begin
            state_q  <= C_IDLE;
            wr_q     <= 1'b0;
            offset_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            offset_q <= offset_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // An arriving event always takes priority over an expiring wait.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        timeout_hit = C_TO_EN && (cnt_q == C_CNT_LAST);
        case (state_q)
            C_IDLE: begin
                if (cmd_valid_i) begin
                    state_d  = C_REQ;
                    wr_d     = cmd_write_i;
                    offset_d = cmd_offset_i;
                    wdata_d  = cmd_wdata_i;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                end
            end
            C_REQ: begin
                if (lmmi_ready_i) begin
                    cnt_d = '0;
                    if (!wr_q && !lmmi_rdata_valid_i) begin
                        state_d = C_RDWAIT;
                    end else begin
                        state_d = C_RESP;
                        rdata_d = wr_q ? '0 : lmmi_rdata_i;
                    end
                end else if (timeout_hit) begin
                    state_d = C_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            C_RDWAIT: begin
                if (lmmi_rdata_valid_i) begin
                    state_d = C_RESP;
                    rdata_d = lmmi_rdata_i;
                end else if (timeout_hit) begin
                    state_d = C_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            C_RESP: begin
                if (rsp_ready_i) begin
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o    = (state_q == C_IDLE);
        busy_o         = (state_q != C_IDLE);
        lmmi_request_o = (state_q == C_REQ);
        rsp_valid_o    = (state_q == C_RESP);
        lmmi_wr_rdn_o  = wr_q;
        lmmi_offset_o  = offset_q;
        lmmi_wdata_o   = wdata_q;
        rsp_rdata_o    = rdata_q;
        rsp_err_o      = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_lmmi_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_lmmi_initiator
// Description : Directed and randomized transactions for lmmi_initiator,
//               checked against a transaction-level timing/result model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lmmi_initiator;

    localparam int OW = 4;
    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [OW-1:0] cmd_offset_i;
    logic [DW-1:0] cmd_wdata_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          lmmi_request_o, lmmi_wr_rdn_o;
    logic [OW-1:0] lmmi_offset_o;
    logic [DW-1:0] lmmi_wdata_o;
    logic          lmmi_ready_i, lmmi_rdata_valid_i;
    logic [DW-1:0] lmmi_rdata_i;
    logic          busy_o;

    int cyc      = 0;
    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lmmi_initiator #(.OFFSET_W(OW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .sync_clk_i         (clk),
        .sync_rst_i         (rst),
        .cmd_valid_i        (cmd_valid_i),
        .cmd_ready_o        (cmd_ready_o),
        .cmd_write_i        (cmd_write_i),
        .cmd_offset_i       (cmd_offset_i),
        .cmd_wdata_i        (cmd_wdata_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_rdata_o        (rsp_rdata_o),
        .rsp_err_o          (rsp_err_o),
        .lmmi_request_o     (lmmi_request_o),
        .lmmi_wr_rdn_o      (lmmi_wr_rdn_o),
        .lmmi_offset_o      (lmmi_offset_o),
        .lmmi_wdata_o       (lmmi_wdata_o),
        .lmmi_ready_i       (lmmi_ready_i),
        .lmmi_rdata_i       (lmmi_rdata_i),
        .lmmi_rdata_valid_i (lmmi_rdata_valid_i),
        .busy_o             (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready_o), 1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata_o), 0);
        chk({tag, "_rsp_err"},   32'(rsp_err_o), 0);
        chk({tag, "_request"},   32'(lmmi_request_o), 0);
        chk({tag, "_wr_rdn"},    32'(lmmi_wr_rdn_o), 0);
        chk({tag, "_offset"},    32'(lmmi_offset_o), 0);
        chk({tag, "_wdata"},     32'(lmmi_wdata_o), 0);
        chk({tag, "_busy"},      32'(busy_o), 0);
    endtask

    // rdy: waiting cycles before lmmi_ready_i; vld: cycles after acceptance
    // until lmmi_rdata_valid_i (0 = same cycle); hold: cycles rsp_ready_i low.
    task automatic run_txn(input bit wr, input logic [OW-1:0] off, input logic [DW-1:0] wd,
                           input int rdy, input int vld, input logic [DW-1:0] rd, input int hold);
        bit            exp_err;
        logic [DW-1:0] exp_data;
        int            exp_req, exp_rdw, exp_lat;
        int            t, req_seen, c0;
        bit            done;

        exp_err  = 1'b0;
        exp_data = '0;
        exp_rdw  = 0;
        if (rdy >= TO) begin
            exp_req = TO;
            exp_err = 1'b1;
        end else begin
            exp_req = rdy + 1;
            if (!wr) begin
                if (vld > TO) begin
                    exp_err = 1'b1;
                    exp_rdw = TO;
                end else begin
                    exp_data = rd;
                    exp_rdw  = vld;
                end
            end
        end
        exp_lat = 1 + exp_req + exp_rdw + hold + 1;

        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready_o), 1);
        cmd_valid_i  = 1'b1;
        cmd_write_i  = wr;
        cmd_offset_i = off;
        cmd_wdata_i  = wd;
        c0 = cyc;
        @(negedge clk);
        cmd_valid_i  = 1'b0;
        cmd_write_i  = 1'($urandom);
        cmd_offset_i = OW'($urandom);
        cmd_wdata_i  = DW'($urandom);

        t = 0;
        req_seen = 0;
        done = 1'b0;
        while (!done) begin
            if (rsp_valid_o) begin
                done = 1'b1;
            end else if (t > 100) begin
                chk("rsp_wait_bound", 32'(rsp_valid_o), 1);
                done = 1'b1;
            end else begin
                if (lmmi_request_o) begin
                    req_seen++;
                    chk("req_wr_rdn", 32'(lmmi_wr_rdn_o), 32'(wr));
                    chk("req_offset", 32'(lmmi_offset_o), 32'(off));
                    chk("req_wdata",  32'(lmmi_wdata_o), 32'(wd));
                end
                chk("busy_active", 32'(busy_o), 1);
                chk("cmd_ready_active", 32'(cmd_ready_o), 0);
                lmmi_ready_i       = (t == rdy);
                lmmi_rdata_valid_i = 1'b0;
                lmmi_rdata_i       = DW'($urandom);
                if (!wr && t == rdy + vld) begin
                    lmmi_rdata_valid_i = 1'b1;
                    lmmi_rdata_i       = rd;
                end else if (t < rdy && ($urandom % 2) == 0) begin
                    lmmi_rdata_valid_i = 1'b1;
                end
                @(negedge clk);
                t++;
            end
        end
        lmmi_ready_i       = 1'b0;
        lmmi_rdata_valid_i = 1'b0;

        chk("rsp_err",       32'(rsp_err_o), 32'(exp_err));
        chk("rsp_rdata",     32'(rsp_rdata_o), 32'(exp_data));
        chk("req_cycles",    32'(req_seen), 32'(exp_req));
        chk("req_low_resp",  32'(lmmi_request_o), 0);
        chk("cmd_ready_resp", 32'(cmd_ready_o), 0);

        for (int i = 0; i < hold; i++) begin
            cmd_valid_i        = 1'b1;
            lmmi_rdata_valid_i = 1'($urandom);
            lmmi_rdata_i       = 8'hFF;
            @(negedge clk);
            chk("hold_valid",     32'(rsp_valid_o), 1);
            chk("hold_rdata",     32'(rsp_rdata_o), 32'(exp_data));
            chk("hold_err",       32'(rsp_err_o), 32'(exp_err));
            chk("hold_cmd_ready", 32'(cmd_ready_o), 0);
        end
        cmd_valid_i        = 1'b0;
        lmmi_rdata_valid_i = 1'b0;
        rsp_ready_i        = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk("rsp_done_valid", 32'(rsp_valid_o), 0);
        chk("cmd_ready_back", 32'(cmd_ready_o), 1);
        chk("busy_idle",      32'(busy_o), 0);
        chk("latency",        32'(cyc - c0), 32'(exp_lat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        cmd_valid_i        = 1'b0;
        cmd_write_i        = 1'b0;
        cmd_offset_i       = '0;
        cmd_wdata_i        = '0;
        rsp_ready_i        = 1'b0;
        lmmi_ready_i       = 1'b0;
        lmmi_rdata_i       = '0;
        lmmi_rdata_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        run_txn(1'b1, 4'h3, 8'hA5, 2, 0, 8'h00, 0);   // write, ready after 2
        run_txn(1'b0, 4'h7, 8'h00, 0, 4, 8'h5C, 0);   // read through RDWAIT
        run_txn(1'b0, 4'h2, 8'h00, 0, 0, 8'h81, 0);   // read, direct to RESP
        run_txn(1'b1, 4'h1, 8'h11, TO, 0, 8'h00, 0);  // ready never comes
        run_txn(1'b1, 4'h1, 8'h22, TO - 1, 0, 8'h00, 0);
        run_txn(1'b0, 4'h9, 8'h00, 1, TO, 8'h3C, 0);  // data on last RDWAIT cycle
        run_txn(1'b0, 4'h9, 8'h00, 1, TO + 1, 8'h3C, 0);
        run_txn(1'b1, 4'hC, 8'h5A, 0, 0, 8'h00, 5);   // response back-pressure
        run_txn(1'b1, 4'hE, 8'h77, 0, 0, 8'h00, 0);   // minimum-latency write

        // reset while waiting for read data, then a stray data beat
        @(negedge clk);
        cmd_valid_i  = 1'b1;
        cmd_write_i  = 1'b0;
        cmd_offset_i = 4'h5;
        @(negedge clk);
        cmd_valid_i  = 1'b0;
        lmmi_ready_i = 1'b1;
        @(negedge clk);
        lmmi_ready_i = 1'b0;
        chk("rdwait_busy",    32'(busy_o), 1);
        chk("rdwait_request", 32'(lmmi_request_o), 0);
        rst = 1'b1;
        @(negedge clk);
        rst                = 1'b0;
        lmmi_rdata_valid_i = 1'b1;
        lmmi_rdata_i       = 8'hFF;
        @(negedge clk);
        lmmi_rdata_valid_i = 1'b0;
        chk_reset_outputs("mid_reset");
        repeat (3) begin
            @(negedge clk);
            chk("mid_reset_no_rsp", 32'(rsp_valid_o), 0);
        end
        run_txn(1'b0, 4'h5, 8'h00, 1, 2, 8'h6B, 1);

        for (int n = 0; n < 24; n++) begin
            run_txn(1'($urandom), OW'($urandom), DW'($urandom),
                    int'($urandom_range(0, TO + 1)), int'($urandom_range(0, TO + 2)),
                    DW'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lmmi_initiator.md
LMMI_INITIATOR -- requirements
Module: lmmi_initiator

Interface
REQ-001 SHALL have parameter OFFSET_W, default 4, LMMI offset width.
REQ-002 SHALL have parameter DATA_W, default 8, LMMI data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles waiting on one LMMI event; 0 disables timeout.
REQ-004 SHALL have one clock and a synchronous, active-high reset: sync_clk_i  in  1  sole clock, all logic on its rising edge.
REQ-005 sync_rst_i  in  1  synchronous active-high reset.
REQ-006 cmd_valid_i  in  1  command present.
REQ-007 cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-008 cmd_write_i  in  1  1 = write, 0 = read.
REQ-009 cmd_offset_i  in  OFFSET_W  register offset.
REQ-010 cmd_wdata_i  in  DATA_W  write data; ignored for reads.
REQ-011 rsp_valid_o  out  1  response present.
REQ-012 rsp_ready_i  in  1  response consumed when high with rsp_valid_o.
REQ-013 rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors.
REQ-014 rsp_err_o  out  1  transaction timed out.
REQ-015 lmmi_request_o  out  1  LMMI request to responder.
REQ-016 lmmi_wr_rdn_o  out  1  LMMI direction.
REQ-017 lmmi_offset_o  out  OFFSET_W  LMMI offset.
REQ-018 lmmi_wdata_o  out  DATA_W  LMMI write data.
REQ-019 lmmi_ready_i  in  1  responder accepts request.
REQ-020 lmmi_rdata_i  in  DATA_W  responder read data.
REQ-021 lmmi_rdata_valid_i  in  1  lmmi_rdata_i valid.
REQ-022 busy_o  out  1  high in any state except IDLE.

Function
REQ-023 SHALL implement states IDLE, REQ, RDWAIT, RESP; one transaction outstanding at a time.
REQ-024 cmd_ready_o SHALL be high only in IDLE (registered state, no combinational path from any input).
REQ-025 On cmd handshake SHALL register write/offset/wdata, enter REQ next cycle; lmmi_request_o high from that cycle.
REQ-026 In REQ SHALL hold lmmi_request_o, lmmi_wr_rdn_o, lmmi_offset_o, lmmi_wdata_o stable until lmmi_ready_i sampled high.
REQ-027 Request accepted in cycle where lmmi_request_o && lmmi_ready_i; lmmi_request_o SHALL be low the following cycle.
REQ-028 Accepted write: SHALL enter RESP, rsp_err_o=0, rsp_rdata_o=0.
REQ-029 Accepted read with lmmi_rdata_valid_i high same cycle: SHALL capture lmmi_rdata_i, enter RESP; otherwise enter RDWAIT.
REQ-030 In RDWAIT, first cycle with lmmi_rdata_valid_i high SHALL capture lmmi_rdata_i, enter RESP, rsp_err_o=0.
REQ-031 lmmi_rdata_valid_i in IDLE, RESP, or REQ before acceptance SHALL be ignored; no captured-data change.
REQ-032 Timeout counter (width clog2(TIMEOUT+1)) SHALL clear on entry to REQ and RDWAIT, increment each cycle awaited event absent.
REQ-033 If TIMEOUT>0 and counter==TIMEOUT-1 with event absent: SHALL enter RESP with rsp_err_o=1, rsp_rdata_o=0, lmmi_request_o low next cycle; i.e. error after exactly TIMEOUT waiting cycles.
REQ-034 Event and timeout in same cycle: event SHALL win (no error).
REQ-035 In RESP SHALL hold rsp_valid_o=1 and rsp_rdata_o/rsp_err_o stable until rsp_ready_i; then IDLE next cycle.
REQ-036 Minimum throughput: write with lmmi_ready_i tied high and rsp_ready_i tied high SHALL take 3 cycles cmd-accept to next cmd_ready_o.

Reset
REQ-037 sync_rst_i high SHALL force IDLE at next edge, in any state including mid-transaction.
REQ-038 Reset values: cmd_ready_o=1 (after first edge), rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, lmmi_request_o=0, lmmi_wr_rdn_o=0, lmmi_offset_o=0, lmmi_wdata_o=0, busy_o=0, counter=0.
REQ-039 Reset mid-transaction SHALL produce no response; late lmmi_rdata_valid_i afterwards ignored.

Verification
REQ-040 Write offset 0x3 data 0xA5, lmmi_ready_i high after 2 cycles -> request held 3 cycles with stable fields, rsp_valid_o with err=0, rdata=0x00.
REQ-041 Read offset 0x7, ready immediate, rdata_valid 4 cycles later with 0x5C -> RDWAIT, rsp_rdata_o=0x5C, err=0.
REQ-042 Read with ready and rdata_valid same cycle, data 0x81 -> direct REQ->RESP, rsp_rdata_o=0x81.
REQ-043 TIMEOUT=8, lmmi_ready_i never high -> request dropped after 8 cycles, rsp_err_o=1, rdata=0; repeat with ready on 8th waiting cycle -> err=0.
REQ-044 rsp_ready_i low 5 cycles -> response stable, cmd_ready_o low, new cmd_valid_i not accepted until release.
REQ-045 sync_rst_i pulsed in RDWAIT, then stray rdata_valid 0xFF -> no rsp_valid_o, all outputs at reset values, next command completes normally.
